// File: rtl/bp_fe_pred_write_sched_if.sv
// Table write port of the predictor write scheduler.
// The master side issues a write and the slave side accepts it with w_yumi_i.
interface bp_fe_pred_write_sched_if #(
    parameter int pkt_width_p = 96,
    parameter int idx_width_p = 6
);
    logic                   w_v_o;
    logic [pkt_width_p-1:0] w_pkt_o;
    logic                   w_init_o;
    logic [idx_width_p-1:0] w_idx_o;
    logic                   w_force_o;
    logic                   w_yumi_i;

    modport master (
        output w_v_o,
        output w_pkt_o,
        output w_init_o,
        output w_idx_o,
        output w_force_o,
        input  w_yumi_i
    );

    modport slave (
        input  w_v_o,
        input  w_pkt_o,
        input  w_init_o,
        input  w_idx_o,
        input  w_force_o,
        output w_yumi_i
    );
endinterface

// File: rtl/bp_fe_pred_write_sched.sv
// Predictor table write scheduler: runs an init clear sweep, then merges zero-latency
// redirect writes with a 2-entry attaboy queue whose head is forced after starving.
module bp_fe_pred_write_sched #(
    parameter int pkt_width_p    = 96,
    parameter int idx_width_p    = 6,
    parameter int starve_limit_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        redirect_v_i,
    input  logic [pkt_width_p-1:0]      redirect_pkt_i,
    input  logic                        attaboy_v_i,
    input  logic [pkt_width_p-1:0]      attaboy_pkt_i,
    output logic                        attaboy_ready_o,
    output logic                        redirect_drop_o,
    output logic                        init_done_o,
    bp_fe_pred_write_sched_if.master    w_if
);
    localparam int starve_width_lp = $clog2(starve_limit_p + 1);
    localparam logic [idx_width_p-1:0]     idx_max_lp    = '1;
    localparam logic [starve_width_lp-1:0] starve_lim_lp = starve_width_lp'(starve_limit_p);

    typedef enum logic {e_init, e_run} state_e;

    state_e                     state_q, state_d;
    logic [idx_width_p-1:0]     idx_q, idx_d;
    logic [pkt_width_p-1:0]     fifo_q [2];
    logic [pkt_width_p-1:0]     fifo_d [2];
    logic                       rd_ptr_q, rd_ptr_d;
    logic                       wr_ptr_q, wr_ptr_d;
    logic [1:0]                 count_q, count_d;
    logic [starve_width_lp-1:0] starve_q, starve_d;
    logic                       init_done_q, init_done_d;
    logic                       redirect_drop_q, redirect_drop_d;

    logic                       push, pop, head_v, starve_hit;
    logic                       w_v, w_init, w_force;
    logic [pkt_width_p-1:0]     w_pkt;
    logic [idx_width_p-1:0]     w_idx;

    // Ready depends only on registered state so the producer never sees a loop through attaboy_v_i.
    assign attaboy_ready_o = (state_q == e_run) && (count_q != 2'd2);
    assign head_v          = (count_q != 2'd0);
    assign starve_hit      = (starve_q == starve_lim_lp);
    assign push            = attaboy_v_i & attaboy_ready_o;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        init_done_d     = init_done_q;
        redirect_drop_d = 1'b0;
        w_v             = 1'b0;
        w_init          = 1'b0;
        w_force         = 1'b0;
        w_pkt           = '0;
        w_idx           = '0;
        pop             = 1'b0;

        case (state_q)
            e_init: begin
                w_v             = 1'b1;
                w_init          = 1'b1;
                w_force         = 1'b1;
                w_idx           = idx_q;
                redirect_drop_d = redirect_v_i;
                if (w_if.w_yumi_i) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == idx_max_lp) begin
                        state_d     = e_run;
                        init_done_d = 1'b1;
                    end
                end
            end
            default: begin
                if (redirect_v_i) begin
                    // Redirects are never retried: an unaccepted one is reported and lost.
                    w_v             = 1'b1;
                    w_pkt           = redirect_pkt_i;
                    w_force         = 1'b1;
                    redirect_drop_d = ~w_if.w_yumi_i;
                end else if (head_v) begin
                    w_v     = 1'b1;
                    w_pkt   = fifo_q[rd_ptr_q];
                    w_force = starve_hit;
                    pop     = w_if.w_yumi_i;
                end
            end
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (!head_v || pop) begin
            starve_d = '0;
        end else if (!starve_hit) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_comb begin
            fifo_d[gi] = fifo_q[gi];
            if (push && (wr_ptr_q == 1'(gi))) begin
                fifo_d[gi] = attaboy_pkt_i;
            end
        end

        always_ff @(posedge clk_i) begin
            fifo_q[gi] <= fifo_d[gi];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q         <= e_init;
            idx_q           <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            starve_q        <= '0;
            init_done_q     <= 1'b0;
            redirect_drop_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            starve_q        <= starve_d;
            init_done_q     <= init_done_d;
            redirect_drop_q <= redirect_drop_d;
        end
    end

    assign w_if.w_v_o     = w_v;
    assign w_if.w_pkt_o   = w_pkt;
    assign w_if.w_init_o  = w_init;
    assign w_if.w_idx_o   = w_idx;
    assign w_if.w_force_o = w_force;
    assign init_done_o     = init_done_q;
    assign redirect_drop_o = redirect_drop_q;
endmodule
